comparer_serial: RTL and testbench
==================================

Name: comparer_serial

Overview:
Parametrised successor to the 1-bit board comparator. Compares two WIDTH-bit operands bit-serially, MSB first, one bit per clock, under a start/busy/done handshake. Supports unsigned or two's-complement operands and holds the last lt/eq/gt result on the three board LEDs. Sits between switch/keypad operand sources and the LED bank, for digital-fundamentals demos of sequential datapaths.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.
LED_INV, 0, 1 = LED outputs active-low (the whole led1..led3 pattern is inverted).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  request a compare; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
busy  output  1  high while bits are being compared
done  output  1  one-cycle pulse; the result updates on the same edge
led1  output  1  a<b of the last completed compare, XOR LED_INV
led2  output  1  a==b of the last completed compare, XOR LED_INV
led3  output  1  a>b of the last completed compare, XOR LED_INV

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, busy=0, done=0.
  - Internal lt/eq/gt = 0 (no result yet), so led1..led3 = LED_INV.
  - Shift registers and bit counter = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge E0: capture a, b into shift registers; counter=WIDTH-1; go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (busy=1):
  - Each edge examines bit[counter] of both captured operands.
  - A difference flag records the first differing bit only; later bits cannot change it.
  - Unsigned rule: a bit 0 and b bit 1 gives lt; a bit 1 and b bit 0 gives gt.
  - SIGNED=1, sign bit (counter=WIDTH-1) differs: the operand with bit 1 is the smaller (a=1 gives lt, b=1 gives gt). All lower bits follow the unsigned rule.
  - At counter=0: go to DONE. Otherwise decrement the counter.
  - Edges E1..E_WIDTH process bits WIDTH-1..0.
- DONE (one cycle):
  - done=1; lt/eq/gt registered from the flag on the transition edge. eq=1 iff no bit differed. Exactly one of lt/eq/gt is 1.
  - Next edge: IDLE, done=0.
- Latency: start sampled at E0 → busy high for WIDTH cycles → done high in the cycle after E_WIDTH.
- Handshake rules:
  - start is ignored in SHIFT and DONE; no queuing.
  - start held continuously re-triggers on the IDLE cycle after each DONE, giving a WIDTH+2-cycle period.
  - Changes on a/b after the capture edge do not affect the running compare.
- Result hold: led1..led3 hold the last result through IDLE and through a subsequent SHIFT. They change only on the DONE transition edge or on reset.
- Reset mid-operation: abort immediately to IDLE; busy=0, done=0, leds=LED_INV. The next start behaves as from power-up.
- Counter width is clog2(WIDTH). No wrap: decrement stops at 0.

Optional Feature:
Macro: COMPARER_EARLY_EXIT_EN.
- Defined: on the first differing bit, SHIFT goes directly to DONE on that edge. Latency = (WIDTH - index of the MSB-most differing bit) processing edges. Equal operands still take WIDTH edges.
- Undefined: always exactly WIDTH SHIFT edges, i.e. constant latency regardless of data.

Test Plan:
1. WIDTH=8, SIGNED=0: a=0x5A, b=0x5A, 1-cycle start → busy high 8 cycles; done pulse in cycle 9; led1=0, led2=1, led3=0.
2. WIDTH=8, a=0x80, b=0x7F → SIGNED=0: led3=1, others 0. SIGNED=1: led1=1, others 0.
3. WIDTH=8, a=0x80, b=0x00 → with COMPARER_EARLY_EXIT_EN: busy 1 cycle, done in cycle 2, led3=1. Without the macro: busy 8 cycles, done in cycle 9, same result.
4. Start a=0x03, b=0x05 (expect lt). During busy, set a=0xFF, b=0x00 and pulse start → the second start is ignored; result is led1=1; exactly one done pulse.
5. Reset asserted asynchronously mid-SHIFT (cycle 4) → busy=0, done=0, leds=000 immediately without a clock edge. After release, start a=0x10, b=0x01 → led3=1 after the normal latency.
6. LED_INV=1: after reset led1..led3=111. After compare a=b=0x00 → led1=1, led2=0, led3=1.

Source files
------------

// File: rtl/comparer_serial.sv
// comparer_serial -- bit-serial magnitude comparator with an LED result bank.
//   Purpose : compares two WIDTH-bit operands one bit per clock, MSB first,
//             unsigned or two's-complement, and holds lt/eq/gt on led1..led3.
//   Latency : start accepted at E0, busy for WIDTH cycles (fewer with early
//             exit), done pulses for one cycle with the new result.
//   Backpressure: none; start is only sampled in IDLE, never queued.
//
// Parameters:
//   WIDTH   : operand width, 2..32
//   SIGNED  : 0 = unsigned compare, 1 = two's-complement compare
//   LED_INV : 1 = LEDs active-low (whole led1..led3 pattern inverted)
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : compare request (IDLE only)
//   a, b            : operands, captured on the accepting edge
//   busy            : high while bits are being examined
//   done            : one-cycle pulse, result valid from the same edge
//   led1/led2/led3  : a<b / a==b / a>b of the last completed compare
//
// Build option:
//   COMPARER_EARLY_EXIT_EN : when defined, the first differing bit ends the
//   compare on that edge; otherwise latency is always WIDTH edges.

module comparer_serial #(
  parameter int WIDTH   = 8,
  parameter int SIGNED  = 0,
  parameter int LED_INV = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             led1,
  output logic             led2,
  output logic             led3
);

  localparam int            CW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic          SIGNED_CMP = (SIGNED != 0);
  localparam logic          LED_POL    = (LED_INV != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Captured operands and bit pointer
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // First-difference flag and its direction (1 = a is smaller)
  logic diff_q, diff_d;
  logic dir_lt_q, dir_lt_d;

  // Held result of the last completed compare
  logic lt_q, lt_d;
  logic eq_q, eq_d;
  logic gt_q, gt_d;

  // Per-edge bit evaluation
  logic bit_a;
  logic bit_b;
  logic bit_ne;
  logic on_sign_bit;
  logic bit_lt;
  logic first_hit;
  logic last_bit;
  logic exit_now;
  logic finish;
  logic fin_diff;
  logic fin_lt;

  assign bit_a       = a_q[cnt_q];
  assign bit_b       = b_q[cnt_q];
  assign bit_ne      = bit_a ^ bit_b;
  assign on_sign_bit = SIGNED_CMP && (cnt_q == CNT_TOP);

  // Only meaningful when the bits differ. Unsigned: b holding the 1 means
  // a is smaller. On a two's-complement sign bit the 1 marks the negative,
  // hence smaller, operand.
  assign bit_lt = on_sign_bit ? bit_a : bit_b;

  // The flag latches only the MSB-most difference; lower bits are ignored.
  assign first_hit = (state_q == S_SHIFT) && bit_ne && !diff_q;
  assign last_bit  = (cnt_q == '0);

`ifdef COMPARER_EARLY_EXIT_EN
  assign exit_now = first_hit;
`else
  assign exit_now = 1'b0;
`endif

  assign finish = (state_q == S_SHIFT) && (last_bit || exit_now);

  // Verdict including the bit examined on the finishing edge itself.
  assign fin_diff = diff_q | bit_ne;
  assign fin_lt   = diff_q ? dir_lt_q : bit_lt;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (finish) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs (Moore, straight from the state register)
  // ---------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    dir_lt_d = dir_lt_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    gt_d     = gt_q;

    if (state_q == S_IDLE && start) begin
      a_d      = a;
      b_d      = b;
      cnt_d    = CNT_TOP;
      diff_d   = 1'b0;
      dir_lt_d = 1'b0;
    end

    if (state_q == S_SHIFT) begin
      if (first_hit) begin
        diff_d   = 1'b1;
        dir_lt_d = bit_lt;
      end
      // Saturating decrement: the pointer parks at bit 0.
      if (!last_bit) begin
        cnt_d = cnt_q - CNT_ONE;
      end
      // Result is committed on the edge that enters DONE so that it
      // appears together with the done pulse.
      if (finish) begin
        lt_d = fin_diff & fin_lt;
        gt_d = fin_diff & ~fin_lt;
        eq_d = ~fin_diff;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      diff_q   <= 1'b0;
      dir_lt_q <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      gt_q     <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      dir_lt_q <= dir_lt_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      gt_q     <= gt_d;
    end
  end

  // After reset no result exists, so all three LEDs show the "off" level.
  assign led1 = lt_q ^ LED_POL;
  assign led2 = eq_q ^ LED_POL;
  assign led3 = gt_q ^ LED_POL;

endmodule

// File: tb/tb_comparer_serial.sv
// Testbench for comparer_serial: three instances share the stimulus
// (unsigned, signed, inverted LEDs) and are checked against an
// integer-arithmetic reference model.
module tb_comparer_serial;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;

  logic busy_u, done_u, busy_s, done_s, busy_i, done_i;
  wire  [2:0] led_u, led_s, led_i;

  int n_checks = 0;
  int n_errors = 0;

  logic [2:0] prev_u, prev_s, prev_i;

  always #5 clk = ~clk;

  comparer_serial #(.WIDTH(W), .SIGNED(0), .LED_INV(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy_u), .done(done_u),
    .led1(led_u[2]), .led2(led_u[1]), .led3(led_u[0])
  );

  comparer_serial #(.WIDTH(W), .SIGNED(1), .LED_INV(0)) u_sgn (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy_s), .done(done_s),
    .led1(led_s[2]), .led2(led_s[1]), .led3(led_s[0])
  );

  comparer_serial #(.WIDTH(W), .SIGNED(0), .LED_INV(1)) u_inv (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy_i), .done(done_i),
    .led1(led_i[2]), .led2(led_i[1]), .led3(led_i[0])
  );

  // Reference: {lt, eq, gt} from plain integer comparison.
  function automatic logic [2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input bit sgn, input bit inv);
    logic lt, gt;
    if (sgn) begin
      lt = $signed(x) < $signed(y);
      gt = $signed(x) > $signed(y);
    end else begin
      lt = x < y;
      gt = x > y;
    end
    return {lt, (x == y), gt} ^ {3{inv}};
  endfunction

  // Reference: number of busy cycles for a given operand pair.
  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef COMPARER_EARLY_EXIT_EN
    logic [W-1:0] d;
    d = x ^ y;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) return W - i;
    end
    return W;
`else
    return W;
`endif
  endfunction

  // Drives one compare; reports busy count, done cycle (cycle 1 = first
  // cycle after the accepting edge), LEDs on the last busy cycle, LEDs at
  // done, and stray busy/done cycles afterwards.
  task automatic run_compare(input logic [W-1:0] xa, input logic [W-1:0] xb,
                             input bit interfere,
                             output int nb, output int dcyc,
                             output logic [2:0] hu, output logic [2:0] hs, output logic [2:0] hi,
                             output logic [2:0] ru, output logic [2:0] rs, output logic [2:0] ri,
                             output int tail);
    int cyc;
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; nb = 0;
    hu = led_u; hs = led_s; hi = led_i;
    while (done_u !== 1'b1 && cyc < 200) begin
      if (busy_u === 1'b1) begin
        nb++;
        hu = led_u; hs = led_s; hi = led_i;
      end
      if (cyc == 1) begin
        a = W'($urandom); b = W'($urandom);
      end
      if (interfere && cyc == 2) begin
        a = '1; b = '0; start = 1'b1;
      end else if (interfere && cyc == 3) begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    dcyc = cyc;
    ru = led_u; rs = led_s; ri = led_i;
    tail = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done_u !== 1'b0 || busy_u !== 1'b0) tail++;
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    n_checks++; if ({busy_u, busy_s, busy_i} !== 3'b000) begin n_errors++; $display("FAIL reset_busy: got %b want 000", {busy_u, busy_s, busy_i}); end
    n_checks++; if ({done_u, done_s, done_i} !== 3'b000) begin n_errors++; $display("FAIL reset_done: got %b want 000", {done_u, done_s, done_i}); end
    n_checks++; if (led_u !== 3'b000) begin n_errors++; $display("FAIL reset_led_u: got %b want 000", led_u); end
    n_checks++; if (led_s !== 3'b000) begin n_errors++; $display("FAIL reset_led_s: got %b want 000", led_s); end
    n_checks++; if (led_i !== 3'b111) begin n_errors++; $display("FAIL reset_led_inv: got %b want 111", led_i); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    prev_u = 3'b000; prev_s = 3'b000; prev_i = 3'b111;
  endtask

  task automatic test_equal();
    int nb, dc, tl;
    logic [2:0] hu, hs, hi, ru, rs, ri;
    run_compare(8'h5A, 8'h5A, 1'b0, nb, dc, hu, hs, hi, ru, rs, ri, tl);
    n_checks++; if (nb !== W) begin n_errors++; $display("FAIL eq_busy_cycles: got %0d want %0d", nb, W); end
    n_checks++; if (dc !== W + 1) begin n_errors++; $display("FAIL eq_done_cycle: got %0d want %0d", dc, W + 1); end
    n_checks++; if (ru !== 3'b010) begin n_errors++; $display("FAIL eq_led_u: got %b want 010", ru); end
    n_checks++; if (ri !== 3'b101) begin n_errors++; $display("FAIL eq_led_inv: got %b want 101", ri); end
    n_checks++; if (hu !== prev_u) begin n_errors++; $display("FAIL eq_led_hold: got %b want %b", hu, prev_u); end
    n_checks++; if (tl !== 0) begin n_errors++; $display("FAIL eq_tail: got %0d stray cycles want 0", tl); end
    prev_u = 3'b010; prev_s = 3'b010; prev_i = 3'b101;
  endtask

  task automatic test_sign();
    int nb, dc, tl;
    logic [2:0] hu, hs, hi, ru, rs, ri;
    run_compare(8'h80, 8'h7F, 1'b0, nb, dc, hu, hs, hi, ru, rs, ri, tl);
    n_checks++; if (ru !== 3'b001) begin n_errors++; $display("FAIL sign_unsigned: got %b want 001", ru); end
    n_checks++; if (rs !== 3'b100) begin n_errors++; $display("FAIL sign_signed: got %b want 100", rs); end
    n_checks++; if (hs !== prev_s) begin n_errors++; $display("FAIL sign_hold: got %b want %b", hs, prev_s); end
    n_checks++; if (nb !== model_lat(8'h80, 8'h7F)) begin n_errors++; $display("FAIL sign_busy_cycles: got %0d want %0d", nb, model_lat(8'h80, 8'h7F)); end
    prev_u = 3'b001; prev_s = 3'b100; prev_i = 3'b110;
  endtask

  task automatic test_early_exit();
    int nb, dc, tl, lat;
    logic [2:0] hu, hs, hi, ru, rs, ri;
    lat = model_lat(8'h80, 8'h00);
    run_compare(8'h80, 8'h00, 1'b0, nb, dc, hu, hs, hi, ru, rs, ri, tl);
    n_checks++; if (nb !== lat) begin n_errors++; $display("FAIL exit_busy_cycles: got %0d want %0d", nb, lat); end
    n_checks++; if (dc !== lat + 1) begin n_errors++; $display("FAIL exit_done_cycle: got %0d want %0d", dc, lat + 1); end
    n_checks++; if (ru !== 3'b001) begin n_errors++; $display("FAIL exit_led_u: got %b want 001", ru); end
    n_checks++; if (rs !== 3'b100) begin n_errors++; $display("FAIL exit_led_s: got %b want 100", rs); end
    prev_u = 3'b001; prev_s = 3'b100; prev_i = 3'b110;
  endtask

  task automatic test_ignore_start();
    int nb, dc, tl, lat;
    logic [2:0] hu, hs, hi, ru, rs, ri;
    lat = model_lat(8'h03, 8'h05);
    run_compare(8'h03, 8'h05, 1'b1, nb, dc, hu, hs, hi, ru, rs, ri, tl);
    n_checks++; if (ru !== 3'b100) begin n_errors++; $display("FAIL ign_led_u: got %b want 100", ru); end
    n_checks++; if (rs !== 3'b100) begin n_errors++; $display("FAIL ign_led_s: got %b want 100", rs); end
    n_checks++; if (dc !== lat + 1) begin n_errors++; $display("FAIL ign_done_cycle: got %0d want %0d", dc, lat + 1); end
    n_checks++; if (tl !== 0) begin n_errors++; $display("FAIL ign_second_run: got %0d stray cycles want 0", tl); end
    prev_u = 3'b100; prev_s = 3'b100; prev_i = 3'b011;
  endtask

  task automatic test_reset_mid();
    int nb, dc, tl, lat;
    logic [2:0] hu, hs, hi, ru, rs, ri;
    @(negedge clk);
    a = 8'h5A; b = 8'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy_u !== 1'b1) begin n_errors++; $display("FAIL rmid_busy_before: got %b want 1", busy_u); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy_u !== 1'b0 || done_u !== 1'b0) begin n_errors++; $display("FAIL rmid_busy_done: got %b%b want 00", busy_u, done_u); end
    n_checks++; if (led_u !== 3'b000) begin n_errors++; $display("FAIL rmid_led_u: got %b want 000", led_u); end
    n_checks++; if (led_i !== 3'b111) begin n_errors++; $display("FAIL rmid_led_inv: got %b want 111", led_i); end
    @(negedge clk);
    rst = 1'b0;
    prev_u = 3'b000; prev_s = 3'b000; prev_i = 3'b111;
    lat = model_lat(8'h10, 8'h01);
    run_compare(8'h10, 8'h01, 1'b0, nb, dc, hu, hs, hi, ru, rs, ri, tl);
    n_checks++; if (ru !== 3'b001) begin n_errors++; $display("FAIL rmid_after_led: got %b want 001", ru); end
    n_checks++; if (dc !== lat + 1) begin n_errors++; $display("FAIL rmid_after_done: got %0d want %0d", dc, lat + 1); end
    n_checks++; if (hi !== 3'b111) begin n_errors++; $display("FAIL rmid_after_hold: got %b want 111", hi); end
    prev_u = 3'b001; prev_s = 3'b001; prev_i = 3'b110;
  endtask

  task automatic test_random();
    int nb, dc, tl, lat;
    logic [2:0] hu, hs, hi, ru, rs, ri, eu, es, ei;
    logic [W-1:0] xa, xb;
    for (int it = 0; it < 40; it++) begin
      xa = W'($urandom);
      xb = (it % 5 == 0) ? xa : W'($urandom);
      if (it % 7 == 3) xb = xa ^ W'(1 << $urandom_range(W - 1, 0));
      eu = model(xa, xb, 1'b0, 1'b0);
      es = model(xa, xb, 1'b1, 1'b0);
      ei = model(xa, xb, 1'b0, 1'b1);
      lat = model_lat(xa, xb);
      run_compare(xa, xb, 1'b0, nb, dc, hu, hs, hi, ru, rs, ri, tl);
      n_checks++; if (ru !== eu) begin n_errors++; $display("FAIL rnd_led_u a=%h b=%h: got %b want %b", xa, xb, ru, eu); end
      n_checks++; if (rs !== es) begin n_errors++; $display("FAIL rnd_led_s a=%h b=%h: got %b want %b", xa, xb, rs, es); end
      n_checks++; if (ri !== ei) begin n_errors++; $display("FAIL rnd_led_inv a=%h b=%h: got %b want %b", xa, xb, ri, ei); end
      n_checks++; if (nb !== lat) begin n_errors++; $display("FAIL rnd_busy a=%h b=%h: got %0d want %0d", xa, xb, nb, lat); end
      n_checks++; if (dc !== lat + 1) begin n_errors++; $display("FAIL rnd_done a=%h b=%h: got %0d want %0d", xa, xb, dc, lat + 1); end
      n_checks++; if ({hu, hs} !== {prev_u, prev_s}) begin n_errors++; $display("FAIL rnd_hold: got %b %b want %b %b", hu, hs, prev_u, prev_s); end
      n_checks++; if (tl !== 0) begin n_errors++; $display("FAIL rnd_tail: got %0d want 0", tl); end
      prev_u = eu; prev_s = es; prev_i = ei;
    end
  endtask

  task automatic test_back_to_back();
    int first_d, second_d, lat, ncyc;
    logic [W-1:0] xa, xb;
    logic [2:0] eu;
    xa = W'($urandom);
    xb = W'($urandom);
    lat = model_lat(xa, xb);
    eu = model(xa, xb, 1'b0, 1'b0);
    first_d = -1; second_d = -1;
    ncyc = 2 * (W + 2) + 4;
    @(negedge clk);
    a = xa; b = xb; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (done_u === 1'b1) begin
        if (first_d < 0) first_d = c;
        else if (second_d < 0) second_d = c;
      end
    end
    start = 1'b0;
    n_checks++; if (first_d !== lat + 1) begin n_errors++; $display("FAIL b2b_first_done: got %0d want %0d", first_d, lat + 1); end
    n_checks++; if (second_d - first_d !== lat + 2) begin n_errors++; $display("FAIL b2b_period: got %0d want %0d", second_d - first_d, lat + 2); end
    n_checks++; if (led_u !== eu) begin n_errors++; $display("FAIL b2b_led_u: got %b want %b", led_u, eu); end
    repeat (W + 4) @(negedge clk);
    n_checks++; if (busy_u !== 1'b0) begin n_errors++; $display("FAIL b2b_idle: got busy %b want 0", busy_u); end
    prev_u = eu; prev_s = model(xa, xb, 1'b1, 1'b0); prev_i = model(xa, xb, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_equal();
    test_sign();
    test_early_exit();
    test_ignore_start();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
